// File: rtl/apple1_kbd_pkg.sv
// rtl/apple1_kbd_pkg.sv - shared types, scancode constants and set-2 to Apple-1 ASCII mapping
// Contents: rx_state_t (PS/2 frame receiver states), SC_* scancode constants,
//           sc_to_ascii(code, shift, ctrl) -> {valid, ascii[6:0]}
package apple1_kbd_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_F12    = 8'h07;

    // The Apple-1 has no lower case, so letters ignore shift; ctrl folds letters to 0x01..0x1A.
    function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic shift,
                                               input logic ctrl);
        logic [6:0] a;
        logic       v;
        a = 7'h00;
        v = 1'b1;
        case (code)
            8'h1C: a = 7'h41;  8'h32: a = 7'h42;  8'h21: a = 7'h43;  8'h23: a = 7'h44;
            8'h24: a = 7'h45;  8'h2B: a = 7'h46;  8'h34: a = 7'h47;  8'h33: a = 7'h48;
            8'h43: a = 7'h49;  8'h3B: a = 7'h4A;  8'h42: a = 7'h4B;  8'h4B: a = 7'h4C;
            8'h3A: a = 7'h4D;  8'h31: a = 7'h4E;  8'h44: a = 7'h4F;  8'h4D: a = 7'h50;
            8'h15: a = 7'h51;  8'h2D: a = 7'h52;  8'h1B: a = 7'h53;  8'h2C: a = 7'h54;
            8'h3C: a = 7'h55;  8'h2A: a = 7'h56;  8'h1D: a = 7'h57;  8'h22: a = 7'h58;
            8'h35: a = 7'h59;  8'h1A: a = 7'h5A;
            8'h16: a = shift ? 7'h21 : 7'h31;
            8'h1E: a = shift ? 7'h40 : 7'h32;
            8'h26: a = shift ? 7'h23 : 7'h33;
            8'h25: a = shift ? 7'h24 : 7'h34;
            8'h2E: a = shift ? 7'h25 : 7'h35;
            8'h36: a = shift ? 7'h5E : 7'h36;
            8'h3D: a = shift ? 7'h26 : 7'h37;
            8'h3E: a = shift ? 7'h2A : 7'h38;
            8'h46: a = shift ? 7'h28 : 7'h39;
            8'h45: a = shift ? 7'h29 : 7'h30;
            8'h29: a = 7'h20;
            8'h4E: a = shift ? 7'h5F : 7'h2D;
            8'h55: a = shift ? 7'h2B : 7'h3D;
            8'h54: a = shift ? 7'h7B : 7'h5B;
            8'h5B: a = shift ? 7'h7D : 7'h5D;
            8'h5D: a = shift ? 7'h7C : 7'h5C;
            8'h4C: a = shift ? 7'h3A : 7'h3B;
            8'h52: a = shift ? 7'h22 : 7'h27;
            8'h41: a = shift ? 7'h3C : 7'h2C;
            8'h49: a = shift ? 7'h3E : 7'h2E;
            8'h4A: a = shift ? 7'h3F : 7'h2F;
            8'h0E: a = shift ? 7'h7E : 7'h60;
            SC_ENTER: a = 7'h0D;
            SC_BKSP:  a = 7'h5F;
            SC_ESC:   a = 7'h1B;
            default:  v = 1'b0;
        endcase
        if (ctrl && (a >= 7'h41) && (a <= 7'h5A)) a = a & 7'h1F;
        return {v, a};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM, timeout
// Ports: reset (async, active-high), sys_clock, ps2_clk/ps2_data (raw, asynchronous),
//        frame_vld (1-cycle pulse for a good frame), frame_byte[7:0] (held until the next frame)
module ps2_rx
    import apple1_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       reset,
    input  logic       sys_clock,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       frame_vld,
    output logic [7:0] frame_byte
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]  clk_sync, dat_sync;
    logic        clk_prev;
    logic        fall, bit_in, timeout;
    rx_state_t   state, state_nxt;
    logic [2:0]  bit_cnt, cnt_nxt;
    logic [7:0]  shreg, sh_nxt;
    logic        par, par_nxt, vld_nxt;
    logic [TW-1:0] to_cnt;

    assign fall       = clk_prev & ~clk_sync[1];
    assign bit_in     = dat_sync[1];
    assign timeout    = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign frame_byte = shreg;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            clk_prev  <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par       <= 1'b0;
            frame_vld <= 1'b0;
            to_cnt    <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            shreg     <= sh_nxt;
            par       <= par_nxt;
            frame_vld <= vld_nxt;
            if (state == IDLE || fall) to_cnt <= '0;
            else if (!timeout)         to_cnt <= to_cnt + TW'(1);
        end
    end

    // START means "start bit seen"; its edge carries data bit 0, DATA carries bits 1..7.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sh_nxt    = shreg;
        par_nxt   = par;
        vld_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:   if (!bit_in) state_nxt = START;
                START: begin
                    sh_nxt    = {bit_in, shreg[7:1]};
                    cnt_nxt   = 3'd1;
                    state_nxt = DATA;
                end
                DATA: begin
                    sh_nxt  = {bit_in, shreg[7:1]};
                    cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = bit_in;
                    state_nxt = STOP;
                end
                STOP: begin
                    vld_nxt   = bit_in & (^{shreg, par});
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_port.sv
// rtl/ps2_keyboard_port.sv - Apple-1 PS/2 keyboard port: scancode decoder, KBD/KBDCR read port
// Ports: reset (async, active-high), sys_clock, cpu_clken, ps2_clk, ps2_data, address (0 KBD, 1 KBDCR),
//        r_en, dout[7:0] (combinational), clr_screen (high while F12 held)
// Build option: KBD_FIFO_EN adds a 2**FIFO_AW entry type-ahead FIFO in front of KBD.
module ps2_keyboard_port
    import apple1_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
`ifdef KBD_FIFO_EN
    , parameter int FIFO_AW = 3
`endif
) (
    input  logic       reset,
    input  logic       sys_clock,
    input  logic       cpu_clken,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       address,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic       clr_screen
);

    logic       frame_vld;
    logic [7:0] frame_byte, map;
    logic       ext, brk, shift, ctrl;
    logic       dec_vld;
    logic [6:0] dec_key;
    logic       strobe, clr_read;
    logic [7:0] kbd;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .reset      (reset),
        .sys_clock  (sys_clock),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .frame_vld  (frame_vld),
        .frame_byte (frame_byte)
    );

    assign map      = sc_to_ascii(frame_byte, shift, ctrl);
    assign clr_read = cpu_clken & r_en & ~address;

    // Prefix flags apply to exactly one following byte; extended codes are ignored entirely.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            shift      <= 1'b0;
            ctrl       <= 1'b0;
            clr_screen <= 1'b0;
            dec_vld    <= 1'b0;
            dec_key    <= 7'h00;
        end else begin
            dec_vld <= 1'b0;
            if (frame_vld) begin
                if (frame_byte == SC_E0) begin
                    ext <= 1'b1;
                end else if (frame_byte == SC_F0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext) begin
                        if (frame_byte == SC_LSHIFT || frame_byte == SC_RSHIFT) shift <= !brk;
                        else if (frame_byte == SC_CTRL) ctrl       <= !brk;
                        else if (frame_byte == SC_F12)  clr_screen <= !brk;
                        else if (!brk) begin
                            dec_vld <= map[7];
                            dec_key <= map[6:0];
                        end
                    end
                end
            end
        end
    end

`ifdef KBD_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [6:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push, pop;

    assign pop    = clr_read && (count != '0);
    assign push   = dec_vld && ((count != (FIFO_AW + 1)'(DEPTH)) || pop);
    assign strobe = (count != '0);
    assign kbd    = strobe ? {1'b1, mem[rd_ptr]} : 8'h80;

    always_ff @(posedge sys_clock) begin
        if (push) mem[wr_ptr] <= dec_key;
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)      count <= count + (FIFO_AW + 1)'(1);
            else if (pop && !push) count <= count - (FIFO_AW + 1)'(1);
        end
    end
`else
    logic [7:0] key;

    assign kbd = key;

    // A new key outranks a clearing read in the same cycle.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            key    <= 8'h80;
            strobe <= 1'b0;
        end else if (dec_vld) begin
            key    <= {1'b1, dec_key};
            strobe <= 1'b1;
        end else if (clr_read) begin
            strobe <= 1'b0;
        end
    end
`endif

    always_comb begin
        dout = address ? {strobe, 7'b0} : kbd;
    end

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// tb/tb_ps2_keyboard_port.sv - randomized self-checking bench for ps2_keyboard_port against a key-level model
module tb_ps2_keyboard_port;

    localparam int TO = 1000;

    logic       reset, sys_clock, cpu_clken, ps2_clk, ps2_data, address, r_en;
    logic [7:0] dout;
    logic       clr_screen;
    logic [7:0] cap_kbd, cap_cr, v;

    ps2_keyboard_port #(.TIMEOUT_CYCLES(TO)) dut (
        .reset      (reset),
        .sys_clock  (sys_clock),
        .cpu_clken  (cpu_clken),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .address    (address),
        .r_en       (r_en),
        .dout       (dout),
        .clr_screen (clr_screen)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: US layout described as tables ----------------
    localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIG [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    localparam logic [7:0] PUN [12] = '{8'h29, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
                                        8'h49, 8'h4A, 8'h0E};
    localparam logic [7:0] MISC [10] = '{8'h12, 8'h59, 8'h14, 8'h5A, 8'h66, 8'h76, 8'h07, 8'h05, 8'h0D, 8'h11};
    localparam logic [7:0] PUN_N [12] = '{8'h20, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
                                          8'h2E, 8'h2F, 8'h60};
    localparam logic [7:0] PUN_S [12] = '{8'h20, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
                                          8'h3E, 8'h3F, 8'h7E};
    string dig_n = "1234567890";
    string dig_s = "!@#$%^&*()";

    bit         m_shift, m_ctrl, m_ext, m_brk, m_clr, m_strobe;
    logic [7:0] m_kbd;
    logic [7:0] m_q[$];

    function automatic int ref_ascii(input logic [7:0] code, input bit sh, input bit ct);
        for (int i = 0; i < 26; i++) if (code == LET[i]) return ct ? ((8'h41 + i) & 8'h1F) : (8'h41 + i);
        for (int i = 0; i < 10; i++) if (code == DIG[i]) return sh ? int'(dig_s[i]) : int'(dig_n[i]);
        for (int i = 0; i < 12; i++) if (code == PUN[i]) return sh ? int'(PUN_S[i]) : int'(PUN_N[i]);
        if (code == 8'h5A) return 8'h0D;
        if (code == 8'h66) return 8'h5F;
        if (code == 8'h76) return 8'h1B;
        return -1;
    endfunction

    function automatic void model_reset();
        m_shift = 0; m_ctrl = 0; m_ext = 0; m_brk = 0; m_clr = 0; m_strobe = 0;
        m_kbd = 8'h80;
        m_q.delete();
    endfunction

    function automatic void model_emit(input int a);
`ifdef KBD_FIFO_EN
        if (m_q.size() < 8) m_q.push_back(8'h80 | a[7:0]);
`else
        m_kbd = 8'h80 | a[7:0];
        m_strobe = 1;
`endif
    endfunction

    function automatic void model_read();
`ifdef KBD_FIFO_EN
        if (m_q.size() > 0) void'(m_q.pop_front());
`else
        m_strobe = 0;
`endif
    endfunction

    function automatic logic [7:0] exp_kbd();
`ifdef KBD_FIFO_EN
        return (m_q.size() > 0) ? m_q[0] : 8'h80;
`else
        return m_kbd;
`endif
    endfunction

    function automatic logic [7:0] exp_cr();
`ifdef KBD_FIFO_EN
        return (m_q.size() > 0) ? 8'h80 : 8'h00;
`else
        return m_strobe ? 8'h80 : 8'h00;
`endif
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        bit e, k;
        int a;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            e = m_ext; k = m_brk;
            m_ext = 0; m_brk = 0;
            if (!e) begin
                if (b == 8'h12 || b == 8'h59) m_shift = !k;
                else if (b == 8'h14) m_ctrl = !k;
                else if (b == 8'h07) m_clr = !k;
                else if (!k) begin
                    a = ref_ascii(b, m_shift, m_ctrl);
                    if (a >= 0) model_emit(a);
                end
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    // Sends the first nbits of a frame; rd_at_emit places a clearing read on the cycle the key lands.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit rd_at_emit);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge sys_clock);
            ps2_data = bits[i];
            repeat (3) @(negedge sys_clock);
            ps2_clk = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge sys_clock);
                if (rd_at_emit && i == 10 && k == 3) begin
                    address = 1'b0; r_en = 1'b1; cpu_clken = 1'b1;
                end
                if (rd_at_emit && i == 10 && k == 4) begin
                    r_en = 1'b0; cpu_clken = 1'b0; address = 1'b0;
                    #1 cap_kbd = dout;
                    address = 1'b1;
                    #1 cap_cr = dout;
                    address = 1'b0;
                end
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge sys_clock);
        end
        ps2_data = 1'b1;
    endtask

    task automatic peek(input logic a, output logic [7:0] val);
        @(negedge sys_clock);
        address = a;
        #1 val = dout;
        address = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] r;
        peek(1'b0, r); check({tag, ".kbd"}, r, exp_kbd());
        peek(1'b1, r); check({tag, ".kbdcr"}, r, exp_cr());
        check({tag, ".clr"}, {7'b0, clr_screen}, {7'b0, m_clr});
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
        model_byte(b);
        check_outputs($sformatf("sc%02h", b));
    endtask

    task automatic cpu_access(input logic a, input logic en);
        @(negedge sys_clock);
        address = a; r_en = 1'b1; cpu_clken = en;
        @(negedge sys_clock);
        r_en = 1'b0; cpu_clken = 1'b0; address = 1'b0;
        if (en && !a) model_read();
    endtask

    function automatic logic [7:0] pick_code();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 3) return LET[$urandom_range(0, 25)];
        if (k == 4) return DIG[$urandom_range(0, 9)];
        if (k == 5) return PUN[$urandom_range(0, 11)];
        return MISC[$urandom_range(0, 9)];
    endfunction

    initial begin
        logic [7:0] c;
        int r;
        reset = 1'b1; cpu_clken = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; address = 1'b0; r_en = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clock);
        check_outputs("reset");
        reset = 1'b0;

        send_key(8'h1C);
        peek(0, v); check("a_kbd", v, 8'hC1);
        peek(1, v); check("a_strobe", v, 8'h80);
        send_key(8'hF0); send_key(8'h1C);
        peek(1, v); check("a_break_strobe", v, 8'h80);
        cpu_access(0, 1);
        peek(1, v); check("a_read_clears", v, 8'h00);

        send_key(8'h12); send_key(8'h16);
        peek(0, v); check("shift_1", v, 8'hA1);
        send_key(8'hF0); send_key(8'h12); cpu_access(0, 1);
        send_key(8'h16);
        peek(0, v); check("plain_1", v, 8'hB1);
        cpu_access(0, 1);

        send_key(8'h14); send_key(8'h21);
        peek(0, v); check("ctrl_c", v, 8'h83);
        cpu_access(0, 1); send_key(8'hF0); send_key(8'h14);
        send_key(8'h5A); peek(0, v); check("enter", v, 8'h8D); cpu_access(0, 1);
        send_key(8'h66); peek(0, v); check("bksp", v, 8'hDF); cpu_access(0, 1);
        send_key(8'h76); peek(0, v); check("esc", v, 8'h9B); cpu_access(0, 1);

        cpu_access(0, 0); cpu_access(1, 1);
        check_outputs("no_clear_reads");

        send_frame(8'h1C, 1'b1, 11, 1'b0);
        check_outputs("bad_parity");
        send_frame(8'h1C, 1'b0, 5, 1'b0);
        repeat (TO + 10) @(negedge sys_clock);
        send_key(8'h32);
        peek(0, v); check("after_timeout", v, 8'hC2);

        send_frame(8'h1C, 1'b0, 11, 1'b1);
        model_read(); model_byte(8'h1C);
        check("emit_vs_read.kbd", cap_kbd, 8'hC1);
        check("emit_vs_read.kbdcr", cap_cr, 8'h80);
        check_outputs("emit_vs_read");
        cpu_access(0, 1);

        send_key(8'h07);
        check("f12_make", {7'b0, clr_screen}, 8'h01);
        peek(1, v); check("f12_no_strobe", v, 8'h00);
        send_key(8'hF0); send_key(8'h07);
        check("f12_break", {7'b0, clr_screen}, 8'h00);

        for (int i = 0; i < 9; i++) send_key(LET[i]);
        for (int i = 0; i < 9; i++) begin
            check_outputs($sformatf("drain%0d", i));
            cpu_access(0, 1);
        end
        check_outputs("drained");

        for (int n = 0; n < 100; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                send_frame(LET[$urandom_range(0, 25)], 1'b1, 11, 1'b0);
                check_outputs("rnd_badpar");
            end else if (r < 14) begin
                send_key(8'hE0); send_key(LET[$urandom_range(0, 25)]);
            end else if (r < 30) begin
                c = pick_code();
                send_key(8'hF0); send_key(c);
            end else begin
                send_key(pick_code());
            end
            r = $urandom_range(0, 5);
            if (r <= 1) cpu_access(0, 1);
            else if (r == 2) cpu_access(0, 0);
            else if (r == 3) cpu_access(1, 1);
            check_outputs("rnd");
        end

        send_key(8'h07); send_key(8'h1C);
        send_frame(8'h2B, 1'b0, 4, 1'b0);
        @(negedge sys_clock);
        reset = 1'b1;
        model_reset();
        #1;
        address = 1'b0; #1 check("midreset.kbd", dout, 8'h80);
        address = 1'b1; #1 check("midreset.kbdcr", dout, 8'h00);
        address = 1'b0;
        check("midreset.clr", {7'b0, clr_screen}, 8'h00);
        repeat (2) @(negedge sys_clock);
        reset = 1'b0;
        send_key(8'h2B);
        peek(0, v); check("post_reset_f", v, 8'hC6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
